// File: rtl/counter_driver.sv
// counter_driver: prescaled tick and four-phase preload control feeding the mod-4 counter's
// enb/modo/data inputs; every output is a register.
module counter_driver #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_load_req,
    input  logic [3:0]       i_load_val,
    output logic             o_enb,
    output logic             o_modo,
    output logic [3:0]       o_data,
    output logic             o_load_ack,
    output logic             o_running
);
    typedef enum logic [1:0] {IDLE, RUN, LOAD, ACK} state_t;

    state_t           r_state, w_state;
    logic [DIV_W-1:0] r_pc, w_pc, r_div_q, w_div_q;
    logic             r_ret, w_ret, r_enb, w_enb, r_modo, w_modo, r_ack, w_ack;
    logic [3:0]       r_data, w_data;
    logic             w_in_hs;

    assign w_in_hs = (r_state == LOAD) || (r_state == ACK);

    always_comb begin
        w_state = r_state;
        w_pc    = r_pc;
        w_div_q = r_div_q;
        w_ret   = r_ret;
        w_enb   = 1'b0;
        w_modo  = 1'b0;
        w_data  = r_data;
        w_ack   = r_ack;
        // During a handshake start/stop only retarget where we return to; a fresh
        // start from an idle return target also takes a new divisor.
        if (w_in_hs && i_stop) begin
            w_ret = 1'b0;
        end else if (w_in_hs && i_start) begin
            w_ret   = 1'b1;
            w_div_q = r_ret ? r_div_q : i_div;
        end
        case (r_state)
            IDLE: begin
                if (i_load_req) begin
                    w_state = LOAD;
                    w_data  = i_load_val;
                    w_enb   = 1'b1;
                    w_modo  = 1'b1;
                end else if (i_start && !i_stop) begin
                    w_state = RUN;
                    w_div_q = i_div;
                    w_pc    = '0;
                    w_ret   = 1'b1;
                end
            end
            RUN: begin
                if (i_stop) begin
                    w_state = IDLE;
                    w_ret   = 1'b0;
                    w_pc    = '0;
                end else if (i_load_req) begin
                    w_state = LOAD;
                    w_data  = i_load_val;
                    w_enb   = 1'b1;
                    w_modo  = 1'b1;
                end else if (r_pc == r_div_q) begin
                    w_pc  = '0;
                    w_enb = 1'b1;
                end else begin
                    w_pc = r_pc + 1'b1;
                end
            end
            LOAD: begin
                w_state = ACK;
                w_ack   = 1'b1;
                w_pc    = '0;
            end
            default: begin
                if (!i_load_req) begin
                    w_ack   = 1'b0;
                    w_state = w_ret ? RUN : IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_div_q <= '0;
            r_ret   <= 1'b0;
            r_enb   <= 1'b0;
            r_modo  <= 1'b0;
            r_data  <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pc    <= w_pc;
            r_div_q <= w_div_q;
            r_ret   <= w_ret;
            r_enb   <= w_enb;
            r_modo  <= w_modo;
            r_data  <= w_data;
            r_ack   <= w_ack;
        end
    end

    assign o_enb      = r_enb;
    assign o_modo     = r_modo;
    assign o_data     = r_data;
    assign o_load_ack = r_ack;
    assign o_running  = r_ret;
endmodule

// File: tb/tb_counter_driver.sv
// tb_counter_driver: directed scenarios for counter_driver; outputs are sampled 1ns after
// each rising edge and compared against hand-derived values.
module tb_counter_driver;
    logic       clk = 1'b0;
    logic       rst;
    logic       i_start, i_stop, i_load_req;
    logic [7:0] i_div;
    logic [3:0] i_load_val;
    logic       o_enb, o_modo, o_load_ack, o_running;
    logic [3:0] o_data;
    logic [7:0] obs;
    int         checks = 0;
    int         errors = 0;

    counter_driver #(.DIV_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_stop    (i_stop),
        .i_div     (i_div),
        .i_load_req(i_load_req),
        .i_load_val(i_load_val),
        .o_enb     (o_enb),
        .o_modo    (o_modo),
        .o_data    (o_data),
        .o_load_ack(o_load_ack),
        .o_running (o_running)
    );

    always #5 clk = ~clk;

    // obs = {enb, modo, data, load_ack, running}
    assign obs = {o_enb, o_modo, o_data, o_load_ack, o_running};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_start = 1'b1; i_load_req = 1'b1; i_load_val = 4'hF; i_div = 8'd3;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold[%0d] obs=%b want=%b", i, obs, 8'h00);
            end
        end
        i_start = 1'b0; i_load_req = 1'b0; rst = 1'b1;
        step();
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL reset_release obs=%b want=%b", obs, 8'h00);
        end
    endtask

    task automatic test_prescale();
        i_div = 8'd3; i_start = 1'b1;
        step();
        i_start = 1'b0;
        checks++;
        if ({o_enb, o_running} !== 2'b01) begin
            errors++;
            $display("FAIL prescale_start enb/run=%b want=01", {o_enb, o_running});
        end
        for (int i = 1; i <= 11; i++) begin
            step();
            if (i == 1) i_div = 8'd1;
            checks++;
            if ({o_enb, o_modo} !== {(i % 4 == 0), 1'b0}) begin
                errors++;
                $display("FAIL prescale_tick[%0d] enb/modo=%b want=%b", i, {o_enb, o_modo}, {(i % 4 == 0), 1'b0});
            end
        end
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        checks++;
        if ({o_enb, o_running} !== 2'b00) begin
            errors++;
            $display("FAIL prescale_stop_at_tick enb/run=%b want=00", {o_enb, o_running});
        end
    endtask

    task automatic test_div0();
        i_div = 8'd0; i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if ({o_enb, o_modo, o_running} !== 3'b101) begin
                errors++;
                $display("FAIL div0_cont[%0d] enb/modo/run=%b want=101", i, {o_enb, o_modo, o_running});
            end
        end
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        checks++;
        if ({o_enb, o_running} !== 2'b00) begin
            errors++;
            $display("FAIL div0_stop enb/run=%b want=00", {o_enb, o_running});
        end
    endtask

    task automatic test_load_run();
        i_div = 8'd5; i_start = 1'b1;
        step();
        i_start = 1'b0;
        step(); step();
        i_load_req = 1'b1; i_load_val = 4'h2;
        step();
        checks++;
        if (obs !== {1'b1, 1'b1, 4'h2, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL load_run_entry obs=%b want=%b", obs, {1'b1, 1'b1, 4'h2, 1'b0, 1'b1});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== {1'b0, 1'b0, 4'h2, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL load_run_ack[%0d] obs=%b want=%b", i, obs, {1'b0, 1'b0, 4'h2, 1'b1, 1'b1});
            end
        end
        i_load_req = 1'b0;
        step();
        checks++;
        if ({o_load_ack, o_enb} !== 2'b00) begin
            errors++;
            $display("FAIL load_run_ack_fall ack/enb=%b want=00", {o_load_ack, o_enb});
        end
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if ({o_enb, o_modo, o_data} !== {(i == 6), 1'b0, 4'h2}) begin
                errors++;
                $display("FAIL load_run_resume[%0d] enb/modo/data=%b want=%b", i, {o_enb, o_modo, o_data}, {(i == 6), 1'b0, 4'h2});
            end
        end
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
    endtask

    task automatic test_simultaneous();
        i_div = 8'd5; i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        i_stop = 1'b1; i_load_req = 1'b1; i_load_val = 4'hA;
        step();
        i_stop = 1'b0;
        checks++;
        if ({o_enb, o_modo, o_running} !== 3'b000) begin
            errors++;
            $display("FAIL simul_stop_first enb/modo/run=%b want=000", {o_enb, o_modo, o_running});
        end
        step();
        checks++;
        if (obs !== {1'b1, 1'b1, 4'hA, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL simul_load obs=%b want=%b", obs, {1'b1, 1'b1, 4'hA, 1'b0, 1'b0});
        end
        step();
        i_load_req = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({o_enb, o_load_ack, o_running} !== 3'b000) begin
                errors++;
                $display("FAIL simul_idle[%0d] enb/ack/run=%b want=000", i, {o_enb, o_load_ack, o_running});
            end
        end
        i_load_req = 1'b1; i_load_val = 4'h5;
        step();
        step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        checks++;
        if ({o_load_ack, o_running} !== 2'b11) begin
            errors++;
            $display("FAIL simul_start_in_ack ack/run=%b want=11", {o_load_ack, o_running});
        end
        i_load_req = 1'b0;
        step();
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if ({o_enb, o_modo, o_data} !== {(i == 6), 1'b0, 4'h5}) begin
                errors++;
                $display("FAIL simul_resume[%0d] enb/modo/data=%b want=%b", i, {o_enb, o_modo, o_data}, {(i == 6), 1'b0, 4'h5});
            end
        end
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
    endtask

    task automatic test_reset_mid();
        i_load_req = 1'b1; i_load_val = 4'h7;
        step();
        step();
        checks++;
        if (o_load_ack !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ack_up ack=%b want=1", o_load_ack);
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_clear obs=%b want=%b", obs, 8'h00);
        end
        rst = 1'b1;
        step();
        checks++;
        if (obs !== {1'b1, 1'b1, 4'h7, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_reload obs=%b want=%b", obs, {1'b1, 1'b1, 4'h7, 1'b0, 1'b0});
        end
        step();
        i_load_req = 1'b0;
        step();
        checks++;
        if ({o_load_ack, o_running, o_enb} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_done ack/run/enb=%b want=000", {o_load_ack, o_running, o_enb});
        end
    endtask

    initial begin
        rst = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_load_req = 1'b0;
        i_div = '0; i_load_val = '0;
        #1;
        test_reset();
        test_prescale();
        test_div0();
        test_load_run();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
